// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding and R/W direction bit values.
// Used by both the read master and the I2C target block.
package i2c_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StAddr,
      StAddrAck,
      StRdata,
      StMack,
      StWaitFull,
      StStop
   } i2c_state_e;

   localparam logic READ_BIT  = 1'b1;
   localparam logic WRITE_BIT = 1'b0;

endpackage

// File: rtl/i2c_clk_gen.sv
// Quarter-bit timebase: divides rd_clk by QTR_DIV, emits a tick strobe and a
// 2-bit quarter index that advances on every tick. clr wins over en.
module i2c_clk_gen #(
   parameter int unsigned QTR_DIV = 125
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       clr,
   output logic       tick,
   output logic [1:0] qtr
);

   localparam int unsigned CW = (QTR_DIV > 1) ? $clog2(QTR_DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    qtr_q, qtr_d;

   always_comb begin
      tick  = en && (cnt_q == CW'(QTR_DIV - 1));
      cnt_d = cnt_q;
      qtr_d = qtr_q;
      if (clr) begin
         cnt_d = '0;
         qtr_d = '0;
      end else if (tick) begin
         cnt_d = '0;
         qtr_d = qtr_q + 2'd1;
      end else if (en) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         qtr_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         qtr_q <= qtr_d;
      end
   end

   assign qtr = qtr_q;

endmodule

// File: rtl/i2c_read_master.sv
// I2C read-only master: START, 7-bit address + R, then cmd_len bytes with
// master ACK/NACK, STOP. All bus activity is paced by quarter-bit ticks.
module i2c_read_master
   import i2c_pkg::*;
#(
   parameter int unsigned QTR_DIV = 125,
   parameter int unsigned MAX_LEN = 255
) (
   input  logic       rd_clk,
   input  logic       rd_rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [6:0] cmd_addr,
   input  logic [7:0] cmd_len,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_full,
   output logic       done,
   output logic       nack_err,
   output logic       scl,
   inout  wire        sda
);

   localparam logic [7:0] MaxLen = 8'(MAX_LEN);

   i2c_state_e state_q, state_d;
   logic       scl_q, scl_d, sda_oe_q, sda_oe_d;
   logic [7:0] shift_q, shift_d, remain_q, remain_d, rx_data_q, rx_data_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic       ack_q, ack_d, nack_q, nack_d;
   logic       rx_valid_q, rx_valid_d, done_q, done_d;
   logic       tick, clk_en, clk_clr, bit_end, sda_in;
   logic [1:0] qtr, nq;

   assign sda_in  = sda;
   assign sda     = sda_oe_q ? 1'b0 : 1'bz;
   assign clk_clr = (state_q == StIdle);
   assign clk_en  = (state_q != StIdle) && (state_q != StWaitFull);

   i2c_clk_gen #(
      .QTR_DIV(QTR_DIV)
   ) u_clk_gen (
      .clk  (rd_clk),
      .rst_n(rd_rst_n),
      .en   (clk_en),
      .clr  (clk_clr),
      .tick (tick),
      .qtr  (qtr)
   );

   always_comb begin
      state_d    = state_q;
      scl_d      = scl_q;
      sda_oe_d   = sda_oe_q;
      shift_d    = shift_q;
      remain_d   = remain_q;
      rx_data_d  = rx_data_q;
      bit_cnt_d  = bit_cnt_q;
      ack_d      = ack_q;
      nack_d     = nack_q;
      rx_valid_d = 1'b0;
      done_d     = 1'b0;
      bit_end    = 1'b0;
      nq         = qtr + 2'd1;

      // Actions are keyed to the quarter being entered on this tick.
      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               state_d  = StStart;
               shift_d  = {cmd_addr, READ_BIT};
               nack_d   = 1'b0;
               scl_d    = 1'b1;
               sda_oe_d = 1'b0;
               if (cmd_len == 8'd0)       remain_d = 8'd1;
               else if (cmd_len > MaxLen) remain_d = MaxLen;
               else                       remain_d = cmd_len;
            end
         end
         StStart: begin
            if (tick) begin
               if (nq == 2'd1) sda_oe_d = 1'b1;
               if (nq == 2'd3) scl_d = 1'b0;
               if (nq == 2'd0) begin
                  state_d   = StAddr;
                  sda_oe_d  = ~shift_q[7];
                  bit_cnt_d = '0;
               end
            end
         end
         StAddr, StAddrAck, StRdata, StMack: begin
            if (tick) begin
               unique case (nq)
                  2'd1: scl_d = 1'b1;
                  2'd2: begin
                     ack_d = sda_in;
                     if (state_q == StRdata) shift_d = {shift_q[6:0], sda_in};
                  end
                  2'd3: scl_d = 1'b0;
                  default: bit_end = 1'b1;
               endcase
            end
         end
         StWaitFull: begin
            if (!rx_full) begin
               state_d   = StRdata;
               bit_cnt_d = '0;
            end
         end
         StStop: begin
            if (tick) begin
               if (nq == 2'd1) scl_d = 1'b1;
               if (nq == 2'd3) sda_oe_d = 1'b0;
               if (nq == 2'd0) begin
                  done_d  = 1'b1;
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (bit_end) begin
         unique case (state_q)
            StAddr: begin
               if (bit_cnt_q == 3'd7) begin
                  state_d  = StAddrAck;
                  sda_oe_d = 1'b0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  shift_d   = {shift_q[6:0], 1'b0};
                  sda_oe_d  = ~shift_q[6];
               end
            end
            StAddrAck: begin
               if (ack_q) begin
                  nack_d   = 1'b1;
                  state_d  = StStop;
                  sda_oe_d = 1'b1;
               end else begin
                  state_d   = StRdata;
                  bit_cnt_d = '0;
                  sda_oe_d  = 1'b0;
               end
            end
            StRdata: begin
               if (bit_cnt_q == 3'd7) begin
                  rx_data_d  = shift_q;
                  rx_valid_d = 1'b1;
                  state_d    = StMack;
                  sda_oe_d   = (remain_q > 8'd1);
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
            default: begin
               // StMack: saturating decrement so the counter never wraps.
               remain_d = (remain_q > 8'd1) ? remain_q - 8'd1 : 8'd0;
               if (remain_q <= 8'd1) begin
                  state_d  = StStop;
                  sda_oe_d = 1'b1;
               end else begin
                  sda_oe_d  = 1'b0;
                  bit_cnt_d = '0;
                  state_d   = rx_full ? StWaitFull : StRdata;
               end
            end
         endcase
      end
   end

   always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
         state_q    <= StIdle;
         scl_q      <= 1'b1;
         sda_oe_q   <= 1'b0;
         shift_q    <= '0;
         remain_q   <= '0;
         rx_data_q  <= '0;
         bit_cnt_q  <= '0;
         ack_q      <= 1'b0;
         nack_q     <= 1'b0;
         rx_valid_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         scl_q      <= scl_d;
         sda_oe_q   <= sda_oe_d;
         shift_q    <= shift_d;
         remain_q   <= remain_d;
         rx_data_q  <= rx_data_d;
         bit_cnt_q  <= bit_cnt_d;
         ack_q      <= ack_d;
         nack_q     <= nack_d;
         rx_valid_q <= rx_valid_d;
         done_q     <= done_d;
      end
   end

   assign cmd_ready = (state_q == StIdle);
   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign done      = done_q;
   assign nack_err  = done_q & nack_q;
   assign scl       = scl_q;

endmodule

// File: tb/tb_i2c_read_master.sv
// Bench for i2c_read_master: behavioural I2C target, table-driven and random
// commands against a transaction-level model, plus reset/busy sequences.
module tb_i2c_read_master;

   localparam int unsigned QTR = 4;
   localparam int unsigned MAXL = 255;

   logic       rd_clk = 1'b0;
   logic       rd_rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [6:0] cmd_addr = '0;
   logic [7:0] cmd_len = '0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_full = 1'b0;
   logic       done, nack_err, scl;
   wire        sda;
   logic       tgt_oe = 1'b0;
   logic       sda_bus;

   pullup (sda);
   assign sda     = (tgt_oe && rd_rst_n) ? 1'b0 : 1'bz;
   assign sda_bus = (sda === 1'b0) ? 1'b0 : 1'b1;

   i2c_read_master #(
      .QTR_DIV(QTR),
      .MAX_LEN(MAXL)
   ) dut (
      .rd_clk   (rd_clk),
      .rd_rst_n (rd_rst_n),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_addr (cmd_addr),
      .cmd_len  (cmd_len),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_full  (rx_full),
      .done     (done),
      .nack_err (nack_err),
      .scl      (scl),
      .sda      (sda)
   );

   always #5 rd_clk = ~rd_clk;

   int cyc = 0;
   always @(posedge rd_clk) cyc <= cyc + 1;

   int checks = 0, errors = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   // ---------------- behavioural I2C target ----------------
   logic [6:0] tgt_addr = '0;
   bit         tgt_resp = 1'b0;
   logic [7:0] tgt_bytes [0:15];
   logic [7:0] exp_bytes [0:15];
   logic       mack_q [$];
   int         start_cnt = 0, stop_cnt = 0;

   initial begin : target
      int   s_cnt;
      bit   s_active, s_acked, s_nacked;
      logic [7:0] s_addr_sh;
      logic scl_p, sda_p;
      s_cnt = 0; s_active = 0; s_acked = 0; s_nacked = 0; s_addr_sh = '0;
      scl_p = 1'b1; sda_p = 1'b1;
      forever begin
         @(negedge rd_clk);
         if (!rd_rst_n) begin
            s_active = 0;
            tgt_oe   = 1'b0;
         end else if (scl && scl_p && sda_p && !sda_bus) begin
            start_cnt++;
            s_active = 1; s_cnt = 0; s_acked = 0; s_nacked = 0; tgt_oe = 1'b0;
         end else if (scl && scl_p && !sda_p && sda_bus) begin
            stop_cnt++;
            s_active = 0; tgt_oe = 1'b0;
         end else if (s_active && scl && !scl_p) begin
            if (s_cnt < 8) s_addr_sh = {s_addr_sh[6:0], sda_bus};
            else if (s_cnt > 8 && s_cnt % 9 == 8 && s_acked && !s_nacked) begin
               mack_q.push_back(sda_bus);
               if (sda_bus) s_nacked = 1;
            end
            s_cnt++;
         end else if (s_active && !scl && scl_p) begin
            tgt_oe = 1'b0;
            if (s_cnt == 8) begin
               s_acked = tgt_resp && (s_addr_sh == {tgt_addr, 1'b1});
               tgt_oe  = s_acked;
            end else if (s_cnt > 8 && s_acked && !s_nacked && s_cnt % 9 != 8) begin
               tgt_oe = ~tgt_bytes[s_cnt / 9 - 1][7 - (s_cnt % 9)];
            end
         end
         scl_p = scl;
         sda_p = sda_bus;
      end
   end

   // ---------------- output monitor ----------------
   logic [7:0] rx_q [$];
   int   done_cnt = 0, overlap = 0, last_rx_cyc = 0, done_cyc = 0;
   logic done_nack = 1'b0;

   initial begin : monitor
      forever begin
         @(negedge rd_clk);
         if (rx_valid) begin
            rx_q.push_back(rx_data);
            last_rx_cyc = cyc;
         end
         if (done) begin
            done_cnt++;
            done_nack = nack_err;
            done_cyc  = cyc;
         end
         if (rx_valid && done) overlap++;
      end
   end

   // ---------------- downstream back-pressure ----------------
   int stall_req = 0, stall_tag = 0, stall_served = 0, stall_viol = 0;

   initial begin : stall_proc
      forever begin
         @(negedge rd_clk);
         if (rx_valid && stall_tag != stall_served) begin
            stall_served = stall_tag;
            rx_full = 1'b1;
            for (int k = 1; k <= stall_req; k++) begin
               @(negedge rd_clk);
               if (k > 4 * QTR && scl !== 1'b0) stall_viol++;
            end
            rx_full = 1'b0;
         end
      end
   end

   // Transaction-level model: bytes the master must deliver for a command.
   function automatic int model_n(input logic [7:0] l, input bit resp);
      int eff;
      eff = (l == 8'd0) ? 1 : ((int'(l) > MAXL) ? MAXL : int'(l));
      return resp ? eff : 0;
   endfunction

   task automatic wait_done(input string nm, input int db);
      int t;
      t = 0;
      while (done_cnt == db && t < 6000) begin
         @(negedge rd_clk);
         t++;
      end
      check({nm, "_done_in_time"}, 32'(t < 6000), 32'd1);
   endtask

   task automatic run_cmd(input string nm, input logic [6:0] a, input logic [7:0] l,
                          input bit resp, input int stall, input int exp_n, input bit exp_nack);
      int rb, db, sb, mb, ob, vb;
      logic [31:0] got;
      rb = rx_q.size(); db = done_cnt; sb = stop_cnt; mb = mack_q.size();
      ob = overlap; vb = stall_viol;
      tgt_addr = a;
      tgt_resp = resp;
      if (stall > 0) begin
         stall_req = stall;
         stall_tag++;
      end
      @(negedge rd_clk);
      cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
      @(negedge rd_clk);
      cmd_valid = 1'b0;
      wait_done(nm, db);
      repeat (4 * QTR) @(negedge rd_clk);
      check({nm, "_done_pulses"}, 32'(done_cnt - db), 32'd1);
      check({nm, "_nack_err"}, 32'(done_nack), 32'(exp_nack));
      check({nm, "_rx_count"}, 32'(rx_q.size() - rb), 32'(exp_n));
      check({nm, "_mack_count"}, 32'(mack_q.size() - mb), 32'(exp_n));
      for (int i = 0; i < exp_n; i++) begin
         got = (rb + i < rx_q.size()) ? 32'(rx_q[rb + i]) : 32'hdead;
         check($sformatf("%s_byte%0d", nm, i), got, 32'(exp_bytes[i]));
         got = (mb + i < mack_q.size()) ? 32'(mack_q[mb + i]) : 32'hdead;
         check($sformatf("%s_mack%0d", nm, i), got, (i == exp_n - 1) ? 32'd1 : 32'd0);
      end
      check({nm, "_stop_seen"}, 32'(stop_cnt - sb), 32'd1);
      check({nm, "_no_overlap"}, 32'(overlap - ob), 32'd0);
      if (exp_n > 0)
         check({nm, "_done_gap"}, 32'(done_cyc - last_rx_cyc >= 4 * QTR), 32'd1);
      if (stall > 0) check({nm, "_scl_low_stall"}, 32'(stall_viol - vb), 32'd0);
      check({nm, "_ready_after"}, 32'(cmd_ready), 32'd1);
   endtask

   typedef struct {
      string      name;
      logic [6:0] addr;
      logic [7:0] len;
      bit         resp;
      int         stall;
      logic [23:0] data;   // byte i at data[8*i +: 8]
      int         exp_n;
      bit         exp_nack;
   } vec_t;

   vec_t vecs [4];

   initial begin
      int db, sb, rb, t;
      logic [6:0] ra;
      logic [7:0] rl;
      bit rr;

      vecs[0] = '{"rd3",   7'h25, 8'd3, 1'b1, 0,   {8'hFF, 8'h3C, 8'hA5}, 3, 1'b0};
      vecs[1] = '{"noack", 7'h11, 8'd1, 1'b0, 0,   24'h0,                 0, 1'b1};
      vecs[2] = '{"stall", 7'h40, 8'd2, 1'b1, 500, {8'h00, 8'h34, 8'h12}, 2, 1'b0};
      vecs[3] = '{"len0",  7'h7F, 8'd0, 1'b1, 0,   {8'h00, 8'h00, 8'h5A}, 1, 1'b0};

      repeat (3) @(negedge rd_clk);
      check("rst_scl", 32'(scl), 32'd1);
      check("rst_sda", 32'(sda_bus), 32'd1);
      check("rst_ready", 32'(cmd_ready), 32'd1);
      check("rst_rx_valid", 32'(rx_valid), 32'd0);
      check("rst_rx_data", 32'(rx_data), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_nack", 32'(nack_err), 32'd0);
      rd_rst_n = 1'b1;
      repeat (3) @(negedge rd_clk);

      foreach (vecs[v]) begin
         for (int i = 0; i < 16; i++) begin
            tgt_bytes[i] = (i < 3) ? vecs[v].data[8 * i +: 8] : 8'hEE;
            exp_bytes[i] = tgt_bytes[i];
         end
         run_cmd(vecs[v].name, vecs[v].addr, vecs[v].len, vecs[v].resp, vecs[v].stall,
                 vecs[v].exp_n, vecs[v].exp_nack);
      end

      for (int r = 0; r < 6; r++) begin
         ra = 7'($urandom_range(0, 127));
         rl = 8'($urandom_range(0, 4));
         rr = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < 16; i++) begin
            tgt_bytes[i] = 8'($urandom_range(0, 255));
            exp_bytes[i] = tgt_bytes[i];
         end
         run_cmd($sformatf("rand%0d", r), ra, rl, rr, 0, model_n(rl, rr), !rr);
      end

      // Reset in the middle of the second data byte.
      for (int i = 0; i < 16; i++) tgt_bytes[i] = 8'h00;
      tgt_addr = 7'h33; tgt_resp = 1'b1;
      rb = rx_q.size();
      @(negedge rd_clk);
      cmd_addr = 7'h33; cmd_len = 8'd3; cmd_valid = 1'b1;
      @(negedge rd_clk);
      cmd_valid = 1'b0;
      t = 0;
      while (rx_q.size() == rb && t < 3000) begin
         @(negedge rd_clk);
         t++;
      end
      check("rst_mid_first_byte", 32'(t < 3000), 32'd1);
      repeat (4 * QTR + 6 * QTR) @(negedge rd_clk);
      db = done_cnt;
      #2 rd_rst_n = 1'b0;
      @(negedge rd_clk);
      check("rst_mid_scl", 32'(scl), 32'd1);
      check("rst_mid_sda", 32'(sda_bus), 32'd1);
      check("rst_mid_ready", 32'(cmd_ready), 32'd1);
      repeat (2) @(negedge rd_clk);
      rd_rst_n = 1'b1;
      repeat (200) @(negedge rd_clk);
      check("rst_mid_no_done", 32'(done_cnt - db), 32'd0);

      // cmd_valid while busy must be ignored.
      tgt_bytes[0] = 8'h81; tgt_bytes[1] = 8'h7E;
      tgt_addr = 7'h25; tgt_resp = 1'b1;
      db = done_cnt; sb = start_cnt; rb = rx_q.size();
      @(negedge rd_clk);
      cmd_addr = 7'h25; cmd_len = 8'd2; cmd_valid = 1'b1;
      @(negedge rd_clk);
      cmd_valid = 1'b0;
      repeat (50) @(negedge rd_clk);
      check("busy_ready_low", 32'(cmd_ready), 32'd0);
      cmd_addr = 7'h11; cmd_len = 8'd1; cmd_valid = 1'b1;
      @(negedge rd_clk);
      cmd_valid = 1'b0;
      wait_done("busy", db);
      repeat (100) @(negedge rd_clk);
      check("busy_one_start", 32'(start_cnt - sb), 32'd1);
      check("busy_one_done", 32'(done_cnt - db), 32'd1);
      check("busy_rx_count", 32'(rx_q.size() - rb), 32'd2);
      exp_bytes[0] = 8'h81; exp_bytes[1] = 8'h7E;
      run_cmd("second", 7'h25, 8'd2, 1'b1, 0, 2, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
